// File: rtl/poly_mul_negacyclic_seq_if.sv
// Handshake and data bundle for poly_mul_negacyclic_seq.
//   in_valid/in_ready : operand pair handshake (a_flat, b_flat)
//   out_valid/out_ready : product handshake (c_flat)
//   busy : high while the MAC datapath is working
//   in_acc : accumulate-into-C select, present only with POLYMUL_ACCUM_EN
// Coefficient k of every polynomial sits at bits [k*COEF_W +: COEF_W].
interface poly_mul_negacyclic_seq_if #(
  parameter int N      = 4,
  parameter int COEF_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N*COEF_W-1:0]   a_flat;
  logic [N*COEF_W-1:0]   b_flat;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*COEF_W-1:0]   c_flat;
  logic                  busy;
`ifdef POLYMUL_ACCUM_EN
  logic                  in_acc;
`endif

  // Producer/consumer side
  modport master (
`ifdef POLYMUL_ACCUM_EN
    output in_acc,
`endif
    output in_valid, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, c_flat, busy
  );

  // Multiplier side
  modport slave (
`ifdef POLYMUL_ACCUM_EN
    input  in_acc,
`endif
    input  in_valid, a_flat, b_flat, out_ready,
    output in_ready, out_valid, c_flat, busy
  );
endinterface

// File: rtl/poly_mul_negacyclic_seq.sv
// Sequential negacyclic polynomial multiplier over Z_Q[x]/(x^N+1).
// One shared multiply-accumulate: output coefficient k is built over N
// cycles (j = 0..N-1) from a[(k-j) mod N]*b[j], subtracting the wrapped
// terms because x^N = -1, then reduced into [0, Q-1].
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : poly_mul_negacyclic_seq_if.slave (operand/product handshakes, busy)
// Optional feature macro: POLYMUL_ACCUM_EN -- adds bus.in_acc; when set at
// capture, each coefficient accumulator is seeded with the held c_flat
// coefficient so the result is C_old + A*B.
// Latency: capture edge 0, out_valid high after edge N*N.
module poly_mul_negacyclic_seq #(
  parameter int N      = 4,
  parameter int Q      = 17,
  parameter int COEF_W = 5,
  parameter int ACC_W  = 2*COEF_W + $clog2(N) + 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  poly_mul_negacyclic_seq_if.slave   bus
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0]            LAST = IW'(N-1);
  localparam logic signed [ACC_W-1:0]  Q_S  = ACC_W'(Q);

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_e;

  state_e                        state_q;
  logic [N-1:0][COEF_W-1:0]      a_q, b_q, c_q;
  logic [IW-1:0]                 k_q, j_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic                          in_ready_q, out_valid_q, busy_q;

  // ---- datapath ----
  logic [IW-1:0]                 i_idx, k_inc;
  logic [2*COEF_W-1:0]           prod;
  logic signed [ACC_W-1:0]       term, acc_d, rem, red;
  logic [COEF_W-1:0]             coef_d;
  logic signed [ACC_W-1:0]       seed_cap, seed_next;

  // IW-bit subtraction wraps, giving (k-j) mod N for power-of-two N
  assign i_idx = k_q - j_q;
  assign k_inc = k_q + 1'b1;
  assign prod  = a_q[i_idx] * b_q[j_q];
  assign term  = signed'(ACC_W'(prod));
  // Terms with j > k come from i+j >= N and pick up the x^N = -1 sign
  assign acc_d = (j_q <= k_q) ? acc_q + term : acc_q - term;

  // Signed % truncates toward zero; fold negative remainders back up
  assign rem    = acc_d % Q_S;
  assign red    = (rem < 0) ? rem + Q_S : rem;
  assign coef_d = COEF_W'(red);

`ifdef POLYMUL_ACCUM_EN
  logic acc_mode_q;
  // Seeds come from the held product; coefficient k+1 is still the old
  // value when coefficient k is written back, so the read is safe.
  assign seed_cap  = bus.in_acc ? signed'(ACC_W'(c_q[0]))     : '0;
  assign seed_next = acc_mode_q ? signed'(ACC_W'(c_q[k_inc])) : '0;
`else
  assign seed_cap  = '0;
  assign seed_next = '0;
`endif

  // ---- control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef POLYMUL_ACCUM_EN
      acc_mode_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a_flat;
            b_q        <= bus.b_flat;
            k_q        <= '0;
            j_q        <= '0;
            acc_q      <= seed_cap;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= MAC;
`ifdef POLYMUL_ACCUM_EN
            acc_mode_q <= bus.in_acc;
`endif
          end
        end
        MAC: begin
          if (j_q == LAST) begin
            c_q[k_q] <= coef_d;
            j_q      <= '0;
            k_q      <= k_inc;
            acc_q    <= seed_next;
            if (k_q == LAST) begin
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end else begin
            acc_q <= acc_d;
            j_q   <= j_q + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.c_flat    = c_q;

endmodule

// File: tb/tb_poly_mul_negacyclic_seq.sv
module tb_poly_mul_negacyclic_seq;
  localparam int N = 4;
  localparam int Q = 17;
  localparam int W = 5;

  typedef logic [N*W-1:0] poly_t;
  typedef struct {
    poly_t a;
    poly_t b;
    poly_t c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  poly_mul_negacyclic_seq_if #(.N(N), .COEF_W(W)) bus();

  poly_mul_negacyclic_seq #(.N(N), .Q(Q), .COEF_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_chk  = 0;
  int    n_fail = 0;
  poly_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic poly_t pk(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  // Schoolbook reference: c[i+j] += a_i*b_j, wrapping i+j>=N with a minus sign
  function automatic poly_t ref_mul(input poly_t a, input poly_t b, input poly_t cin);
    int    s[N];
    poly_t r;
    for (int k = 0; k < N; k++) s[k] = int'(cin[k*W +: W]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int p;
        p = int'(a[i*W +: W]) * int'(b[j*W +: W]);
        if (i + j < N) s[i+j]   += p;
        else           s[i+j-N] -= p;
      end
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(((s[k] % Q) + Q) % Q);
    return r;
  endfunction

  function automatic poly_t rnd_poly();
    poly_t p;
    for (int k = 0; k < N; k++) p[k*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    return p;
  endfunction

  task automatic accept();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_accept", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_accept",  32'(bus.in_ready),  32'd1);
  endtask

  // Capture one operand pair; leaves the bench #1 after the capture edge
  task automatic capture(input poly_t a, input poly_t b, input logic acc, input poly_t exp);
    int t = 0;
    while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
    check("in_ready_before_capture", 32'(bus.in_ready), 32'd1);
    bus.a_flat   = a;
    bus.b_flat   = b;
`ifdef POLYMUL_ACCUM_EN
    bus.in_acc   = acc;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    bus.in_valid = 1'b0;
    bus.a_flat   = '1;
    bus.b_flat   = '1;
    check("busy_in_mac",     32'(bus.busy),     32'd1);
    check("in_ready_in_mac", 32'(bus.in_ready), 32'd0);
    if (acc === 1'bx) n_chk += 0;
  endtask

  task automatic run_op(input poly_t a, input poly_t b, input logic acc, input poly_t exp, input bit rel);
    int    cyc = 0;
    poly_t e;
    capture(a, b, acc, exp);
    while (!bus.out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("latency", 32'(cyc), 32'(N*N));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("c_flat", 32'(bus.c_flat), 32'(e));
    end else begin
      check("scoreboard_empty", 32'd1, 32'(exp_q.size()));
    end
    if (rel) accept();
  endtask

  vec_t  tbl[8];
  poly_t held;

  initial begin
    // directed vectors (coefficient 0 first)
    tbl[0] = '{pk(1,2,3,4),     pk(5,6,7,8),     pk(12,15,2,9)};
    tbl[1] = '{pk(1,0,0,0),     pk(3,16,0,5),    pk(3,16,0,5)};
    tbl[2] = '{pk(0,1,0,0),     pk(0,0,0,1),     pk(16,0,0,0)};
    // all-31 operands: c_k = 961*(2k-2), 961 = 9 mod 17
    tbl[3] = '{pk(31,31,31,31), pk(31,31,31,31), pk(16,0,1,2)};
    for (int r = 4; r < 8; r++) begin
      tbl[r].a = rnd_poly();
      tbl[r].b = rnd_poly();
      tbl[r].c = ref_mul(tbl[r].a, tbl[r].b, '0);
    end

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_flat    = '0;
    bus.b_flat    = '0;
`ifdef POLYMUL_ACCUM_EN
    bus.in_acc    = 1'b0;
`endif
    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_c_flat",    32'(bus.c_flat),    32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) run_op(tbl[v].a, tbl[v].b, 1'b0, tbl[v].c, 1'b1);

    // HOLD: product stays put for 10 cycles, stray in_valid ignored
    held = pk(12,15,2,9);
    run_op(pk(1,2,3,4), pk(5,6,7,8), 1'b0, held, 1'b0);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c == 3);
      bus.a_flat   = pk(7,7,7,7);
      bus.b_flat   = pk(3,3,3,3);
      @(posedge clk); #1;
      check("hold_c_flat",    32'(bus.c_flat),    32'(held));
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    accept();
    @(posedge clk); #1;
    check("idle_busy",   32'(bus.busy),   32'd0);
    check("idle_c_kept", 32'(bus.c_flat), 32'(held));

    // Reset 5 cycles into MAC
    capture(pk(1,2,3,4), pk(5,6,7,8), 1'b0, held);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_c_flat",    32'(bus.c_flat),    32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run_op(pk(0,1,0,0), pk(0,0,0,1), 1'b0, pk(16,0,0,0), 1'b1);

`ifdef POLYMUL_ACCUM_EN
    run_op(pk(1,2,3,4), pk(5,6,7,8), 1'b0, pk(12,15,2,9),  1'b1);
    run_op(pk(1,0,0,0), pk(1,1,1,1), 1'b1, pk(13,16,3,10), 1'b1);
    run_op(pk(1,0,0,0), pk(1,1,1,1), 1'b0, pk(1,1,1,1),    1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
